keypad_press_generator: RTL and testbench

- Sequential emulator for the "key side" of the 4x4 hex keypad interface; it is the transmitter counterpart of the keypad scanner.
- Takes press commands over a valid/ready handshake and drives a 16-bit one-hot Key bus (Key[i] = hex key i) with a programmable press-bounce, hold time, release-bounce and minimum release gap.
- Key feeds the existing row-signal logic, synchronizer and scanner chain, both for FPGA self-test and for closed-loop simulation of the scanner.

---
 rtl/keypad_press_generator.sv | 135 +++++++++++++
 tb/tb_keypad_press_generator.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/keypad_press_generator.sv
// keypad_press_generator: drives a one-hot 16-key bus with bounce, hold, release bounce and release gap.
// Each accepted command produces exactly one press/release sequence followed by a done pulse.
module keypad_press_generator #(
    parameter int HOLD_W        = 16,
    parameter int BOUNCE_PERIOD = 4,
    parameter int GAP_CYCLES    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_code,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [2:0]        cmd_bounces,
    input  logic              abort,
    output logic [15:0]       Key,
    output logic              busy,
    output logic              done
);
    localparam int PW = BOUNCE_PERIOD > 1 ? $clog2(BOUNCE_PERIOD) : 1;
    localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(BOUNCE_PERIOD - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP} state_t;

    state_t            state_q;
    logic [3:0]        code_q;
    logic [HOLD_W-1:0] hold_q;
    logic [2:0]        bnc_q;
    logic [HOLD_W-1:0] cnt_q;
    logic [3:0]        half_q;
    logic [PW-1:0]     per_q;
    logic [GW-1:0]     gap_q;
    logic [15:0]       key_q;
    logic              done_q;

    logic [15:0]       oh_d, oh_in_d;
    logic [HOLD_W-1:0] hold_in_d, hold_lat_d;
    logic [3:0]        half_last_d;
    logic              per_end_d;

    // Hold counter is loaded with max(hold,1)-1 so all-ones never wraps.
    always_comb begin
        oh_d        = 16'h0001 << code_q;
        oh_in_d     = 16'h0001 << cmd_code;
        hold_in_d   = cmd_hold == '0 ? '0 : cmd_hold - 1'b1;
        hold_lat_d  = hold_q == '0 ? '0 : hold_q - 1'b1;
        half_last_d = {bnc_q, 1'b0} - 4'd1;
        per_end_d   = per_q == PER_LAST;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            code_q  <= '0;
            hold_q  <= '0;
            bnc_q   <= '0;
            cnt_q   <= '0;
            half_q  <= '0;
            per_q   <= '0;
            gap_q   <= '0;
            key_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort && (state_q == BOUNCE_IN || state_q == HOLD || state_q == BOUNCE_OUT)) begin
                state_q <= GAP;
                key_q   <= '0;
                gap_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: if (cmd_valid) begin
                        code_q  <= cmd_code;
                        hold_q  <= cmd_hold;
                        bnc_q   <= cmd_bounces;
                        per_q   <= '0;
                        half_q  <= '0;
                        cnt_q   <= hold_in_d;
                        key_q   <= oh_in_d;
                        state_q <= cmd_bounces != 3'd0 ? BOUNCE_IN : HOLD;
                    end
                    BOUNCE_IN: if (per_end_d) begin
                        per_q  <= '0;
                        half_q <= half_q + 4'd1;
                        if (half_q == half_last_d) begin
                            state_q <= HOLD;
                            cnt_q   <= hold_lat_d;
                            key_q   <= oh_d;
                        end else begin
                            key_q <= half_q[0] ? oh_d : '0;
                        end
                    end else begin
                        per_q <= per_q + 1'b1;
                    end
                    HOLD: if (cnt_q == '0) begin
                        state_q <= bnc_q != 3'd0 ? BOUNCE_OUT : GAP;
                        key_q   <= '0;
                        half_q  <= '0;
                        per_q   <= '0;
                        gap_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                    BOUNCE_OUT: if (per_end_d) begin
                        per_q  <= '0;
                        half_q <= half_q + 4'd1;
                        if (half_q == half_last_d) begin
                            state_q <= GAP;
                            gap_q   <= '0;
                            key_q   <= '0;
                        end else begin
                            key_q <= half_q[0] ? '0 : oh_d;
                        end
                    end else begin
                        per_q <= per_q + 1'b1;
                    end
                    default: if (gap_q == GAP_LAST) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        cmd_ready = state_q == IDLE;
        busy      = state_q != IDLE;
        Key       = key_q;
        done      = done_q;
    end
endmodule

// File: tb/tb_keypad_press_generator.sv
// tb_keypad_press_generator: directed press sequences with hand-computed Key waveforms.
// Default parameters: BOUNCE_PERIOD=4, GAP_CYCLES=8.
module tb_keypad_press_generator;
    logic        clock, reset, cmd_valid, cmd_ready, abort, busy, done;
    logic [3:0]  cmd_code;
    logic [15:0] cmd_hold;
    logic [2:0]  cmd_bounces;
    logic [15:0] Key;
    int n_cmp = 0;
    int n_bad = 0;

    keypad_press_generator dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_code(cmd_code), .cmd_hold(cmd_hold), .cmd_bounces(cmd_bounces),
        .abort(abort), .Key(Key), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (!reset) begin
        n_cmp++;
        assert ($onehot0(Key)) else begin
            n_bad++;
            $error("FAIL onehot: Key=%h required zero or one-hot", Key);
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic seg(input string tag, input logic [15:0] k, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, Key, k);
            chk({tag, "_busy"}, {15'd0, busy}, 16'd1);
            chk({tag, "_done"}, {15'd0, done}, 16'd0);
            chk({tag, "_ready"}, {15'd0, cmd_ready}, 16'd0);
            step();
        end
    endtask

    task automatic fin(input string tag);
        chk({tag, "_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_ready"}, {15'd0, cmd_ready}, 16'd1);
        chk({tag, "_key"}, Key, 16'h0000);
    endtask

    task automatic cmd(input logic [3:0] c, input logic [15:0] h, input logic [2:0] b);
        cmd_valid = 1'b1; cmd_code = c; cmd_hold = h; cmd_bounces = b;
        step();
        cmd_valid = 1'b0; cmd_code = ~c; cmd_hold = 16'hffff; cmd_bounces = 3'd7;
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; abort = 1'b0;
        cmd_code = '0; cmd_hold = '0; cmd_bounces = '0;
        #12;
        chk("rst_key", Key, 16'h0000);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_ready", {15'd0, cmd_ready}, 16'd1);
        chk("rst_done", {15'd0, done}, 16'd0);
        reset = 1'b0;
        step();

        cmd(4'd5, 16'd5, 3'd0);
        seg("t1_hold", 16'h0020, 5);
        seg("t1_gap", 16'h0000, 8);
        fin("t1_end");
        step();
        chk("t1_done_once", {15'd0, done}, 16'd0);

        cmd(4'd10, 16'd3, 3'd2);
        seg("t2_bi0", 16'h0400, 4);
        seg("t2_bi1", 16'h0000, 4);
        seg("t2_bi2", 16'h0400, 4);
        seg("t2_bi3", 16'h0000, 4);
        seg("t2_hold", 16'h0400, 3);
        seg("t2_bo0", 16'h0000, 4);
        seg("t2_bo1", 16'h0400, 4);
        seg("t2_bo2", 16'h0000, 4);
        seg("t2_bo3", 16'h0400, 4);
        seg("t2_gap", 16'h0000, 8);
        fin("t2_end");
        step();

        cmd(4'd15, 16'd0, 3'd0);
        seg("t3_hold", 16'h8000, 1);
        seg("t3_gap", 16'h0000, 8);
        fin("t3_end");
        step();

        cmd(4'd3, 16'd100, 3'd0);
        seg("t4_hold", 16'h0008, 9);
        chk("t4_hold10", Key, 16'h0008);
        abort = 1'b1;
        step();
        abort = 1'b0;
        seg("t4_gap", 16'h0000, 8);
        fin("t4_end");
        abort = 1'b1;
        cmd(4'd1, 16'd2, 3'd0);
        abort = 1'b0;
        seg("t4b_hold", 16'h0002, 2);
        seg("t4b_gap_a", 16'h0000, 3);
        abort = 1'b1;
        seg("t4b_gap_abort", 16'h0000, 1);
        abort = 1'b0;
        seg("t4b_gap_b", 16'h0000, 4);
        fin("t4b_end");
        step();

        cmd(4'd7, 16'd4, 3'd1);
        seg("t5_bi0", 16'h0080, 2);
        reset = 1'b1;
        #2;
        chk("t5_rst_key", Key, 16'h0000);
        chk("t5_rst_busy", {15'd0, busy}, 16'd0);
        chk("t5_rst_ready", {15'd0, cmd_ready}, 16'd1);
        step();
        reset = 1'b0;
        for (int i = 0; i < 25; i++) begin
            chk("t5_post_key", Key, 16'h0000);
            chk("t5_post_done", {15'd0, done}, 16'd0);
            chk("t5_post_busy", {15'd0, busy}, 16'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
